// File: rtl/cv32e40x_alu_b_clmul_seq.sv
// Iterative carry-less multiplier for CLMUL / CLMULH / CLMULR.
// Consumes BITS_PER_CYCLE bits of the multiplier per busy cycle and
// accumulates into a 2*XLEN-bit product register.
// Optional early termination when the remaining multiplier bits are all
// zero is enabled by defining the macro CLMUL_ZERO_SKIP_EN.
module cv32e40x_alu_b_clmul_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [1:0]      operator_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int NSTEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state_reg;
    logic [XLEN-1:0]     a_reg;
    logic [XLEN-1:0]     b_reg;
    logic [1:0]          op_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic [CW-1:0]       cnt_reg;

    logic [31:0]         shamt;
    logic [2*XLEN-1:0]   a_base;
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     b_shift;
    logic                last_step;
    logic [2*XLEN-1:0]   pp [BITS_PER_CYCLE];

    // Multiplicand aligned to the bit position of this cycle's first multiplier bit.
    assign shamt  = 32'(cnt_reg) * 32'(BITS_PER_CYCLE);
    assign a_base = {{XLEN{1'b0}}, a_reg} << shamt;

    // One partial product per multiplier bit handled this cycle.
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
        assign pp[gi] = b_reg[gi] ? (a_base << gi) : '0;
    end

    // XOR-fold this cycle's partial products into the accumulator.
    always_comb begin
        acc_next = acc_reg;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            acc_next = acc_next ^ pp[j];
        end
    end

    assign b_shift = b_reg >> BITS_PER_CYCLE;

`ifdef CLMUL_ZERO_SKIP_EN
    // Finish early once no set multiplier bits remain.
    assign last_step = (cnt_reg == CNT_LAST) || (b_shift == '0);
`else
    assign last_step = (cnt_reg == CNT_LAST);
`endif

    // Control FSM and datapath registers; kill aborts from any state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (kill_i) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        a_reg     <= op_a_i;
                        b_reg     <= op_b_i;
                        op_reg    <= operator_i;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    b_reg   <= b_shift;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_step) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign valid_o = (state_reg == DONE);

    // Select the requested product slice; forced to zero outside DONE.
    always_comb begin
        result_o = '0;
        if (state_reg == DONE) begin
            case (op_reg)
                2'b00:   result_o = acc_reg[XLEN-1:0];
                2'b10:   result_o = acc_reg[2*XLEN-2:XLEN-1];
                default: result_o = acc_reg[2*XLEN-1:XLEN];
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40x_alu_b_clmul_seq.sv
// Directed testbench for cv32e40x_alu_b_clmul_seq (XLEN=32, BITS_PER_CYCLE=4).
// Expected latencies follow CLMUL_ZERO_SKIP_EN when that macro is defined.
module tb_cv32e40x_alu_b_clmul_seq;

    localparam int XLEN = 32;
    localparam int BPC  = 4;

    logic            clk;
    logic            rst_n;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [1:0]      operator_i;
    logic            kill_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;

    cv32e40x_alu_b_clmul_seq #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .operator_i (operator_i),
        .kill_i     (kill_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected edges from acceptance to valid_o for a given multiplier.
    function automatic int exp_lat(input logic [XLEN-1:0] b);
`ifdef CLMUL_ZERO_SKIP_EN
        int msb;
        msb = -1;
        for (int i = 0; i < XLEN; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + BPC) / BPC;
`else
        return XLEN / BPC;
`endif
    endfunction

    // Accept one request and wait (bounded) for valid_o; returns edge count.
    task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [1:0] op, output int lat);
        valid_i    = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        operator_i = op;
        @(posedge clk); #1;
        valid_i    = 1'b0;
        op_a_i     = 32'hDEAD_BEEF;
        op_b_i     = 32'hCAFE_F00D;
        operator_i = 2'b01;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (valid_o) break;
        end
    endtask

    task automatic check_op(input string name, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [1:0] op,
                            input logic [XLEN-1:0] exp);
        int lat;
        issue(a, b, op, lat);
        n_cmp++;
        if (lat !== exp_lat(b)) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat(b));
        end
        n_cmp++;
        if (result_o !== exp) begin
            n_bad++;
            $display("FAIL %s result: got %h, expected %h", name, result_o, exp);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s return_idle: ready_o=%b valid_o=%b, expected 1/0", name, ready_o, valid_o);
        end
        $display("op %s a=%h b=%h op=%0d -> result=%h latency=%0d", name, a, b, op, exp, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
        op_a_i = '0; op_b_i = '0; operator_i = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h, expected 1/0/0", ready_o, valid_o, result_o);
        end
        $display("reset: ready=%b valid=%b result=%h", ready_o, valid_o, result_o);
    endtask

    task automatic test_basic();
        check_op("clmul_3x3",      32'h3,        32'h3,        2'b00, 32'h0000_0005);
        check_op("clmul_msb",      32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000);
        check_op("clmulh_msb",     32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000);
        check_op("clmulr_msb",     32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000);
        check_op("clmul_ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555);
        check_op("clmulh_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h5555_5555);
        check_op("clmulh_alias11", 32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000);
        check_op("clmul_5x7",      32'h5,        32'h7,        2'b00, 32'h0000_001B);
        check_op("clmul_b_0x100",  32'h3,        32'h0000_0100, 2'b00, 32'h0000_0300);
        check_op("clmul_a_zero",   32'h0,        32'h1234_5678, 2'b00, 32'h0000_0000);
        check_op("clmulh_b_zero",  32'hFFFF_FFFF, 32'h0,        2'b01, 32'h0000_0000);
    endtask

    task automatic test_hold();
        int lat;
        int unstable;
        ready_i = 1'b0;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, lat);
        n_cmp++;
        if (valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_valid_rise: valid_o=%b after %0d edges, expected 1", valid_o, lat);
        end
        // Try to push a new request while the result is held.
        valid_i = 1'b1; op_a_i = 32'h1; op_b_i = 32'h1; operator_i = 2'b00;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b1 || result_o !== 32'h5555_5555 || ready_o !== 1'b0) unstable++;
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL hold_stable: %0d unstable cycles (valid=%b result=%h ready=%b), expected 0",
                     unstable, valid_o, result_o, ready_o);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_no_reaccept: ready_o=%b valid_o=%b, expected 1/0", ready_o, valid_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_next_accept: ready_o=%b, expected 0 (busy)", ready_o);
        end
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (result_o !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL hold_followup: got %h, expected 00000001", result_o);
        end
        @(posedge clk); #1;
        $display("hold: 5 stalled cycles, unstable=%0d, follow-up result ok", unstable);
    endtask

    task automatic test_kill();
        int seen;
        valid_i = 1'b1; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF; operator_i = 2'b00;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL kill_idle: ready_o=%b valid_o=%b, expected 1/0", ready_o, valid_o);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL kill_no_valid: valid_o high %0d cycles, expected 0", seen);
        end
        // kill in IDLE blocks acceptance
        valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL kill_blocks_accept: ready_o=%b, expected 1", ready_o);
        end
        $display("kill: aborted in 3rd busy cycle, valid seen=%0d", seen);
        check_op("clmul_after_kill", 32'h5, 32'h7, 2'b00, 32'h0000_001B);
    endtask

    task automatic test_reset_in_done();
        int lat;
        ready_i = 1'b0;
        issue(32'h5, 32'h7, 2'b00, lat);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_i = 1'b1;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
            n_bad++;
            $display("FAIL reset_in_done: ready=%b valid=%b result=%h, expected 1/0/0", ready_o, valid_o, result_o);
        end
        $display("reset during DONE: ready=%b valid=%b result=%h", ready_o, valid_o, result_o);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_kill();
        test_reset_in_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cv32e40x_alu_b_clmul_seq.md
Name: cv32e40x_alu_b_clmul_seq

Overview:
Iterative, parametrised carry-less multiplier for the Zbc operations CLMUL, CLMULH and CLMULR. It processes BITS_PER_CYCLE bits of op_b per clock, trading latency for area relative to a fully combinational array. It sits beside the ALU as a multi-cycle unit, with a valid/ready handshake on input and output and a kill input for pipeline flushes.

Parameters:
XLEN, 32, operand and result width; must be at least 8.
BITS_PER_CYCLE, 4, number of op_b bits consumed per busy cycle; must divide XLEN exactly, range 1..XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous and active-low
valid_i  input  1  operation request
ready_o  output  1  unit can accept a request
op_a_i  input  XLEN  multiplicand
op_b_i  input  XLEN  multiplier
operator_i  input  2  00=CLMUL, 01=CLMULH, 10=CLMULR, 11=CLMULH (alias)
kill_i  input  1  abort current operation (flush)
valid_o  output  1  result available
ready_i  input  1  consumer takes result
result_o  output  XLEN  selected product slice; 0 whenever valid_o=0

Behaviour:
- FSM states: IDLE, BUSY, DONE. rst_n=0 at a clock edge puts the FSM in IDLE. It also clears the accumulator, counter and operand registers. After reset: ready_o=1, valid_o=0, result_o=0.
- IDLE: ready_o=1. Acceptance happens at a clock edge when valid_i=1 and ready_o=1 and kill_i=0. On acceptance the unit registers op_a, op_b and operator, clears the 2*XLEN-bit accumulator and counter, and moves to BUSY.
- BUSY: ready_o=0, valid_o=0. On each edge, for j in 0..BITS_PER_CYCLE-1: if b_reg[j]=1, then acc ^= (a_reg zero-extended to 2*XLEN) << (cnt*BITS_PER_CYCLE + j).
- BUSY, register updates on the same edge: b_reg >>= BITS_PER_CYCLE and cnt++.
- BUSY exit: when cnt reaches XLEN/BITS_PER_CYCLE-1, the FSM moves to DONE after that edge's update. valid_o therefore first rises exactly XLEN/BITS_PER_CYCLE edges after the acceptance edge.
- DONE: valid_o=1. result_o is acc[XLEN-1:0] for CLMUL, acc[2*XLEN-1:XLEN] for CLMULH/11, and acc[2*XLEN-2:XLEN-1] for CLMULR. acc[2*XLEN-1] is always 0.
- DONE hold rule: result_o and valid_o stay stable while ready_i=0. On an edge with ready_i=1 the FSM returns to IDLE. There is no same-cycle re-accept, because ready_o=0 in DONE. A new request is accepted at the earliest one cycle later.
- kill_i=1 at an edge, in any state, sends the FSM to IDLE and discards the result. kill_i dominates both ready_i and valid_i. kill_i in IDLE blocks acceptance.
- rst_n=0 mid-operation behaves like kill_i and also clears all registers.
- Inputs op_a_i, op_b_i and operator_i are sampled only at acceptance; later changes are ignored.
- Boundary cases: op_a=0 or op_b=0 gives result 0. BITS_PER_CYCLE=XLEN gives latency 1. Counter width is clog2(XLEN/BITS_PER_CYCLE), minimum 1 bit.

Optional Feature:
CLMUL_ZERO_SKIP_EN:
- Defined: in BUSY, if b_reg after the current shift is all-zero, the FSM moves to DONE on that edge regardless of cnt. Latency becomes ceil((index of highest set bit of op_b + 1)/BITS_PER_CYCLE), with a minimum of 1. The result is identical to the fixed-latency path.
- Not defined: fixed latency of XLEN/BITS_PER_CYCLE cycles, and no zero-detect logic is present.

Test Plan:
- XLEN=32, BPC=4, CLMUL a=0x3, b=0x3, ready_i=1 -> valid_o 8 edges after accept, result_o=0x00000005, then ready_o=1 next cycle.
- a=0x80000000, b=0x80000000: CLMUL -> 0x00000000; CLMULH -> 0x40000000; CLMULR -> 0x80000000.
- a=b=0xFFFFFFFF: CLMUL -> 0x55555555; CLMULH -> 0x55555555. In a second run, hold ready_i=0 for 5 cycles: valid_o and result_o stay stable, and the unit accepts nothing until after the handshake.
- kill_i pulsed during the 3rd BUSY cycle -> IDLE next edge, valid_o never rises, ready_o=1. A following CLMUL 0x5 x 0x7 returns 0x0000001B.
- rst_n=0 for one edge during DONE -> valid_o=0, result_o=0, ready_o=1 after that edge.
- With CLMUL_ZERO_SKIP_EN: b=0x3 -> valid_o 1 edge after accept, result correct. b=0x00000100 -> 3 edges. Without the macro both take 8 edges.
